// File: rtl/fetch_pkg.sv
// Shared types and constant tables for the program-fetch sequencer:
// sequencer states, per-program start addresses and the jump/branch target table.
package fetch_pkg;

    localparam int D  = 10;
    localparam int L  = 5;
    localparam int CW = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    typedef logic [D-1:0]  addr_t;
    typedef logic [CW-1:0] count_t;

    localparam addr_t START_ADDR [4] = '{10'd0, 10'd256, 10'd512, 10'd768};

    // Entries are absolute targets for jumps and D-bit two's-complement offsets for branches.
    function automatic addr_t jump_table_entry(input logic [L-1:0] idx);
        addr_t entry;
        case (idx)
            5'd0:    entry = 10'd20;
            5'd1:    entry = 10'h3FE;
            5'd2:    entry = 10'd5;
            5'd3:    entry = 10'h3FF;
            default: entry = '0;
        endcase
        return entry;
    endfunction

endpackage

// File: rtl/fetch_seq_if.sv
// Host handshake and decoder-facing signals of the fetch sequencer, bundled so the
// core top level and the host model connect through a single port.
interface fetch_seq_if import fetch_pkg::*; ();

    logic          req;
    logic [1:0]    prog_sel;
    logic          halt;
    logic          jump;
    logic          branch;
    logic          flag_taken;
    logic [L-1:0]  lut_idx;
    logic [D-1:0]  prog_ctr;
    logic          fetch_en;
    logic          done;
    logic [CW-1:0] cycle_cnt;

    modport master (
        output req, prog_sel, halt, jump, branch, flag_taken, lut_idx,
        input  prog_ctr, fetch_en, done, cycle_cnt
    );

    modport slave (
        input  req, prog_sel, halt, jump, branch, flag_taken, lut_idx,
        output prog_ctr, fetch_en, done, cycle_cnt
    );

endinterface

// File: rtl/jump_lut.sv
// Combinational jump/branch target lookup: maps the instruction's LUT index field
// to its D-bit table entry.
module jump_lut
    import fetch_pkg::*;
(
    input  logic [L-1:0] lut_idx,
    output addr_t        entry
);

    always_comb begin
        entry = jump_table_entry(lut_idx);
    end

endmodule

// File: rtl/fetch_seq.sv
// Program-fetch sequencer: owns the PC, the start/done handshake with the host and the
// executed-cycle counter. Every output comes straight from a flop.
module fetch_seq
    import fetch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    fetch_seq_if.slave bus
);

    state_e state_q, state_d;
    addr_t  prog_ctr_q, prog_ctr_d;
    logic   fetch_en_q, fetch_en_d;
    logic   done_q, done_d;
    count_t cycle_cnt_q, cycle_cnt_d;
    addr_t  lut_entry;

    jump_lut u_jump_lut (
        .lut_idx (bus.lut_idx),
        .entry   (lut_entry)
    );

    always_comb begin
        state_d     = state_q;
        prog_ctr_d  = prog_ctr_q;
        fetch_en_d  = fetch_en_q;
        done_d      = done_q;
        cycle_cnt_d = cycle_cnt_q;

        case (state_q)
            IDLE: begin
                done_d     = 1'b0;
                fetch_en_d = 1'b0;
                prog_ctr_d = '0;
                if (bus.req) begin
                    state_d     = RUN;
                    prog_ctr_d  = START_ADDR[bus.prog_sel];
                    fetch_en_d  = 1'b1;
                    cycle_cnt_d = '0;
                end
            end

            RUN: begin
                // The halt cycle itself is counted; the counter sticks at all-ones.
                if (cycle_cnt_q != '1) begin
                    cycle_cnt_d = cycle_cnt_q + 1'b1;
                end
                if (bus.halt) begin
                    state_d    = DONE;
                    fetch_en_d = 1'b0;
                    done_d     = 1'b1;
                end else if (bus.jump) begin
                    prog_ctr_d = lut_entry;
                end else if (bus.branch && bus.flag_taken) begin
                    prog_ctr_d = prog_ctr_q + lut_entry;
                end else begin
                    prog_ctr_d = prog_ctr_q + 1'b1;
                end
            end

            DONE: begin
                // Host must drop req before another run can start.
                if (!bus.req) begin
                    state_d    = IDLE;
                    prog_ctr_d = '0;
                    done_d     = 1'b0;
                end
            end

            default: begin
                state_d    = IDLE;
                prog_ctr_d = '0;
                fetch_en_d = 1'b0;
                done_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            prog_ctr_q  <= '0;
            fetch_en_q  <= 1'b0;
            done_q      <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            prog_ctr_q  <= prog_ctr_d;
            fetch_en_q  <= fetch_en_d;
            done_q      <= done_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign bus.prog_ctr  = prog_ctr_q;
    assign bus.fetch_en  = fetch_en_q;
    assign bus.done      = done_q;
    assign bus.cycle_cnt = cycle_cnt_q;

endmodule
